// File: rtl/frame_capture_writer.sv
// frame_capture_writer
//   Captures one grayscale frame from the pixel pipeline into a frame buffer.
//   After the last pixel is written, the TX stage is triggered. The buffer is
//   then held stable until the TX stage reports that it has finished.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   capture_req    one-cycle request to capture the next frame (honoured in IDLE only)
//   continuous     re-arm automatically after each transmitted frame
//   pix_valid      pixel strobe
//   pix_sof        first pixel of a frame, qualified by pix_valid
//   pix_data       8-bit grayscale pixel
//   frame_tx_done  TX stage finished sending the frame (honoured in WAIT_TX only)
//   fb_we          frame buffer write enable (registered)
//   fb_wAddr       frame buffer write address (registered)
//   fb_wData       frame buffer write data (registered)
//   tx_trig        one-cycle pulse to start the TX stage
//   busy           high whenever the FSM is not idle
//   sof_err        one-cycle pulse when a frame restarts before completion
module frame_capture_writer #(
  parameter int unsigned IMG_WIDTH  = 176,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture_req,
  input  logic                  continuous,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic [7:0]            pix_data,
  input  logic                  frame_tx_done,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_wAddr,
  output logic [7:0]            fb_wData,
  output logic                  tx_trig,
  output logic                  busy,
  output logic                  sof_err
);

  localparam int unsigned NumPix = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NumPix - 1);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StCapture,
    StTrig,
    StWaitTx
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;  // address of the next non-SOF pixel

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      fb_we    <= 1'b0;
      fb_wAddr <= '0;
      fb_wData <= '0;
      tx_trig  <= 1'b0;
      sof_err  <= 1'b0;
    end else begin
      // Pulse outputs default low; each write strobe lasts exactly one cycle.
      fb_we   <= 1'b0;
      tx_trig <= 1'b0;
      sof_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (capture_req) state_q <= StArmed;
        end
        StArmed: begin
          // Anything before the start of a frame is discarded.
          if (pix_valid && pix_sof) begin
            fb_we    <= 1'b1;
            fb_wAddr <= '0;
            fb_wData <= pix_data;
            cnt_q    <= ADDR_WIDTH'(1);
            state_q  <= StCapture;
          end
        end
        StCapture: begin
          if (pix_valid) begin
            fb_we    <= 1'b1;
            fb_wData <= pix_data;
            if (pix_sof) begin
              // Source restarted mid-frame: flag it and resynchronise to the new frame.
              fb_wAddr <= '0;
              sof_err  <= 1'b1;
              cnt_q    <= ADDR_WIDTH'(1);
            end else begin
              fb_wAddr <= cnt_q;
              if (cnt_q == LastAddr) begin
                state_q <= StTrig;
              end else begin
                cnt_q <= cnt_q + ADDR_WIDTH'(1);
              end
            end
          end
        end
        StTrig: begin
          // Final write is already on the bus this cycle; trigger follows it.
          tx_trig <= 1'b1;
          state_q <= StWaitTx;
        end
        StWaitTx: begin
          if (frame_tx_done) state_q <= continuous ? StArmed : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_frame_capture_writer.sv
// Self-checking bench for frame_capture_writer. A full-size instance covers the
// complete frame, junk/restart handling and reset mid-capture; a tiny instance
// covers the WAIT_TX hold-off and both re-arm paths cheaply.
module tb_frame_capture_writer;

  localparam int NPIX = 176 * 240;
  localparam int SPIX = 4 * 2;

  typedef struct {
    logic        trig;
    logic [31:0] addr;
    logic [7:0]  data;
    logic        serr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  // Full-size instance
  logic        capture_req, continuous, pix_valid, pix_sof, frame_tx_done;
  logic [7:0]  pix_data;
  logic        fb_we, tx_trig, busy, sof_err;
  logic [15:0] fb_waddr;
  logic [7:0]  fb_wdata;

  // Small instance
  logic        s_capture_req, s_continuous, s_pix_valid, s_pix_sof, s_frame_tx_done;
  logic [7:0]  s_pix_data;
  logic        s_fb_we, s_tx_trig, s_busy, s_sof_err;
  logic [2:0]  s_fb_waddr;
  logic [7:0]  s_fb_wdata;

  exp_t q_main[$];
  exp_t q_small[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   last_we[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frame_capture_writer u_dut (
    .clk          (clk),
    .reset        (reset),
    .capture_req  (capture_req),
    .continuous   (continuous),
    .pix_valid    (pix_valid),
    .pix_sof      (pix_sof),
    .pix_data     (pix_data),
    .frame_tx_done(frame_tx_done),
    .fb_we        (fb_we),
    .fb_wAddr     (fb_waddr),
    .fb_wData     (fb_wdata),
    .tx_trig      (tx_trig),
    .busy         (busy),
    .sof_err      (sof_err)
  );

  frame_capture_writer #(
    .IMG_WIDTH (4),
    .IMG_HEIGHT(2)
  ) u_small (
    .clk          (clk),
    .reset        (reset),
    .capture_req  (s_capture_req),
    .continuous   (s_continuous),
    .pix_valid    (s_pix_valid),
    .pix_sof      (s_pix_sof),
    .pix_data     (s_pix_data),
    .frame_tx_done(s_frame_tx_done),
    .fb_we        (s_fb_we),
    .fb_wAddr     (s_fb_waddr),
    .fb_wData     (s_fb_wdata),
    .tx_trig      (s_tx_trig),
    .busy         (s_busy),
    .sof_err      (s_sof_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every write or trigger must match the head of the queue.
  task automatic mon(input int which, input logic we, input logic [31:0] addr,
                     input logic [7:0] data, input logic trig, input logic serr);
    exp_t  e;
    string p;
    int    sz;
    p  = (which == 0) ? "main" : "small";
    sz = (which == 0) ? q_main.size() : q_small.size();
    if (we === 1'b1 || trig === 1'b1) begin
      if (sz == 0) begin
        n_chk++;
        $display("FAIL %s_unexpected: got we=%0b trig=%0b addr=%0d, required no output",
                 p, we, trig, addr);
      end else begin
        if (which == 0) e = q_main.pop_front();
        else            e = q_small.pop_front();
        if (e.trig) begin
          chk({p, "_trig"}, {31'b0, trig}, 32'd1);
          chk({p, "_trig_no_we"}, {31'b0, we}, 32'd0);
          chk({p, "_trig_gap"}, cyc - last_we[which], 32'd1);
        end else begin
          chk({p, "_we"}, {31'b0, we}, 32'd1);
          chk({p, "_we_no_trig"}, {31'b0, trig}, 32'd0);
          chk({p, "_addr"}, addr, e.addr);
          chk({p, "_data"}, {24'b0, data}, {24'b0, e.data});
          chk({p, "_sof_err"}, {31'b0, serr}, {31'b0, e.serr});
        end
      end
    end else if (serr === 1'b1) begin
      n_chk++;
      $display("FAIL %s_stray_sof_err: got 1, required 0", p);
    end
    if (we === 1'b1) last_we[which] = cyc;
  endtask

  always @(negedge clk) begin
    mon(0, fb_we, {16'b0, fb_waddr}, fb_wdata, tx_trig, sof_err);
    mon(1, s_fb_we, {29'b0, s_fb_waddr}, s_fb_wdata, s_tx_trig, s_sof_err);
  end

  task automatic exp_w(input int which, input int addr, input logic [7:0] data, input logic serr);
    exp_t e;
    e.trig = 1'b0; e.addr = addr; e.data = data; e.serr = serr;
    if (which == 0) q_main.push_back(e);
    else            q_small.push_back(e);
  endtask

  task automatic exp_trig(input int which);
    exp_t e;
    e.trig = 1'b1; e.addr = 0; e.data = 8'h00; e.serr = 1'b0;
    if (which == 0) q_main.push_back(e);
    else            q_small.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_pix(input logic sof, input logic [7:0] d);
    pix_valid = 1'b1; pix_sof = sof; pix_data = d;
    step();
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic s_pix(input logic sof, input logic [7:0] d);
    s_pix_valid = 1'b1; s_pix_sof = sof; s_pix_data = d;
    step();
    s_pix_valid = 1'b0; s_pix_sof = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q_main.size() != 0 || q_small.size() != 0) && t < 200) begin
      step();
      t++;
    end
    chk("drain_pending", q_main.size() + q_small.size(), 32'd0);
  endtask

  // One complete small frame: SOF then the remaining pixels, data = 0x10 + addr.
  task automatic s_frame();
    for (int a = 0; a < SPIX; a++) begin
      exp_w(1, a, 8'(16 + a), 1'b0);
      s_pix(a == 0, 8'(16 + a));
    end
    exp_trig(1);
  endtask

  initial begin
    capture_req = 0; continuous = 0; pix_valid = 0; pix_sof = 0; pix_data = 0;
    frame_tx_done = 0;
    s_capture_req = 0; s_continuous = 0; s_pix_valid = 0; s_pix_sof = 0; s_pix_data = 0;
    s_frame_tx_done = 0;
    last_we[0] = 0; last_we[1] = 0;

    // Reset overrides activity on every input.
    reset = 1'b1;
    capture_req = 1; pix_valid = 1; pix_sof = 1; pix_data = 8'hff;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fb_we", {31'b0, fb_we}, 32'd0);
    chk("rst_fb_waddr", {16'b0, fb_waddr}, 32'd0);
    chk("rst_fb_wdata", {24'b0, fb_wdata}, 32'd0);
    chk("rst_tx_trig", {31'b0, tx_trig}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_sof_err", {31'b0, sof_err}, 32'd0);
    chk("rst_small_busy", {31'b0, s_busy}, 32'd0);

    // capture_req in the first cycle after reset is honoured.
    reset = 1'b0; pix_valid = 0; pix_sof = 0;
    capture_req = 1; s_capture_req = 1;
    step();
    capture_req = 0; s_capture_req = 0;
    chk("first_cycle_req_busy", {31'b0, busy}, 32'd1);
    chk("first_cycle_req_small_busy", {31'b0, s_busy}, 32'd1);

    // ---- Small instance: hold-off and both re-arm paths ----
    s_frame_tx_done = 1; step(); s_frame_tx_done = 0;   // ignored in ARMED
    chk("small_done_in_armed_busy", {31'b0, s_busy}, 32'd1);
    for (int a = 0; a < SPIX; a++) begin
      exp_w(1, a, 8'(16 + a), 1'b0);
      s_capture_req = (a == 3);                          // ignored in CAPTURE
      s_pix(a == 0, 8'(16 + a));
    end
    s_capture_req = 0;
    exp_trig(1);
    for (int i = 0; i < 6; i++) s_pix(i[0], 8'(200 + i)); // TRIG/WAIT_TX: no writes
    wait_drain();
    chk("small_wait_tx_busy", {31'b0, s_busy}, 32'd1);
    s_continuous = 0; s_frame_tx_done = 1; step(); s_frame_tx_done = 0;
    chk("small_done_cont0_idle", {31'b0, s_busy}, 32'd0);
    for (int i = 0; i < 4; i++) s_pix(1'b1, 8'(90 + i)); // IDLE: no writes
    s_capture_req = 1; step(); s_capture_req = 0;
    s_frame();
    wait_drain();
    s_continuous = 1; s_frame_tx_done = 1; step(); s_frame_tx_done = 0;
    chk("small_done_cont1_armed", {31'b0, s_busy}, 32'd1);
    exp_w(1, 0, 8'h77, 1'b0);
    s_pix(1'b1, 8'h77);
    exp_w(1, 1, 8'h78, 1'b0);
    s_pix(1'b0, 8'h78);
    wait_drain();

    // ---- Full-size instance ----
    frame_tx_done = 1; step(); frame_tx_done = 0;       // ignored in ARMED
    chk("done_in_armed_busy", {31'b0, busy}, 32'd1);
    pix_sof = 1; step(); pix_sof = 0;                   // SOF without valid
    for (int i = 0; i < 10; i++) m_pix(1'b0, 8'(160 + i)); // pre-SOF junk
    exp_w(0, 0, 8'h00, 1'b0);
    m_pix(1'b1, 8'h00);
    for (int a = 1; a <= 100; a++) begin
      exp_w(0, a, 8'(a), 1'b0);
      capture_req = (a == 50);                           // ignored in CAPTURE
      m_pix(1'b0, 8'(a));
    end
    capture_req = 0;
    // Restart: flagged, written at 0, then a full frame follows.
    exp_w(0, 0, 8'h00, 1'b1);
    m_pix(1'b1, 8'h00);
    for (int a = 1; a < NPIX; a++) begin
      exp_w(0, a, 8'(a), 1'b0);
      m_pix(1'b0, 8'(a));
    end
    exp_trig(0);
    for (int i = 0; i < 20; i++) m_pix(i[0], 8'(i));    // hold-off in TRIG/WAIT_TX
    wait_drain();
    chk("wait_tx_busy", {31'b0, busy}, 32'd1);
    continuous = 1; frame_tx_done = 1; step(); frame_tx_done = 0;
    chk("done_cont1_armed", {31'b0, busy}, 32'd1);

    // Re-armed capture, abandoned by reset after 5000 pixels.
    for (int a = 0; a < 5000; a++) begin
      exp_w(0, a, 8'(a + 3), 1'b0);
      m_pix(a == 0, 8'(a + 3));
    end
    reset = 1; pix_valid = 1; pix_data = 8'h5a;
    step();
    chk("midrst_fb_we", {31'b0, fb_we}, 32'd0);
    chk("midrst_fb_waddr", {16'b0, fb_waddr}, 32'd0);
    chk("midrst_fb_wdata", {24'b0, fb_wdata}, 32'd0);
    chk("midrst_tx_trig", {31'b0, tx_trig}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    reset = 0; pix_valid = 0; continuous = 0;
    for (int i = 0; i < 20; i++) m_pix(i < 2, 8'(i));    // no capture_req: no writes
    repeat (5) step();
    chk("post_rst_idle_busy", {31'b0, busy}, 32'd0);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/frame_capture_writer.md
FRAME_CAPTURE_WRITER -- requirements
Module: frame_capture_writer

Interface
REQ-001 Parameter IMG_WIDTH, default 176, pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 240, lines per frame.
REQ-003 Parameter ADDR_WIDTH, default $clog2(IMG_WIDTH*IMG_HEIGHT), frame buffer address width.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 capture_req  input  1  one-cycle pulse that requests capture of the next frame.
REQ-007 continuous  input  1  when high, re-arm automatically after each transmitted frame.
REQ-008 pix_valid  input  1  pixel strobe from the grayscale pipeline.
REQ-009 pix_sof  input  1  first pixel of a frame; qualified by pix_valid.
REQ-010 pix_data  input  8  grayscale pixel.
REQ-011 frame_tx_done  input  1  pulse from the UART TX stage indicating that the frame has been fully sent.
REQ-012 fb_we  output  1  frame buffer write enable.
REQ-013 fb_wAddr  output  ADDR_WIDTH  frame buffer write address.
REQ-014 fb_wData  output  8  frame buffer write data.
REQ-015 tx_trig  output  1  one-cycle pulse to the UART TX stage edge_tx_trig input.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 sof_err  output  1  one-cycle pulse when a frame restarts before it is complete.

Function
REQ-018 The FSM SHALL have the states IDLE, ARMED, CAPTURE, TRIG and WAIT_TX.
REQ-019 IDLE: capture_req SHALL cause a transition to ARMED; pixels are ignored and nothing is written.
REQ-020 ARMED: pix_valid&&pix_sof SHALL accept that pixel at address 0, set the counter to 1 and go to CAPTURE; pixels that are not SOF SHALL be discarded.
REQ-021 CAPTURE: each pix_valid without pix_sof SHALL write at the current counter, then increment the counter.
REQ-022 Write path SHALL be registered: fb_we/fb_wAddr/fb_wData asserted exactly 1 cycle after the accepted pixel; fb_we high for one cycle per accepted pixel.
REQ-023 The pixel counter SHALL span 0..IMG_WIDTH*IMG_HEIGHT-1 with no wrap. When pixel IMG_WIDTH*IMG_HEIGHT-1 is accepted, the FSM SHALL go to TRIG and accept no further pixels.
REQ-024 CAPTURE with pix_valid&&pix_sof before the frame is complete SHALL pulse sof_err and write that pixel at address 0. The counter SHALL then become 1 and the FSM SHALL stay in CAPTURE.
REQ-025 TRIG SHALL last one cycle: tx_trig=1 for that cycle, which is after the final fb_we has been issued; the next state SHALL be WAIT_TX.
REQ-026 WAIT_TX: pixels SHALL be ignored (no fb_we) so the buffer is stable while the TX stage reads it. A frame_tx_done pulse SHALL cause a transition to ARMED if continuous=1, else to IDLE.
REQ-027 capture_req SHALL be ignored in every state except IDLE; frame_tx_done SHALL be ignored in every state except WAIT_TX.
REQ-028 pix_sof without pix_valid SHALL have no effect in any state.
REQ-029 A single frame-buffer write SHALL never be dropped or duplicated. Back-to-back pix_valid on every cycle SHALL be sustained in CAPTURE.

Reset
REQ-030 While reset is high: state=IDLE, counter=0, fb_we=0, fb_wAddr=0, fb_wData=0, tx_trig=0, busy=0, sof_err=0.
REQ-031 Reset SHALL override every other input in every state. A capture in progress SHALL be abandoned without any further fb_we or tx_trig.
REQ-032 The first cycle after reset SHALL behave as IDLE. A capture_req in that cycle SHALL be honoured.

Verification
REQ-033 Full frame: capture_req, then a frame of 42240 pixels (data=addr[7:0]) streamed back-to-back -> 42240 fb_we pulses at addresses 0..42239. A single tx_trig SHALL follow one cycle after the final write.
REQ-034 Pre-SOF junk: after capture_req, 10 pixels without SOF and then a SOF frame -> the first fb_we is at address 0 with the SOF pixel's data; the junk pixels produce no writes.
REQ-035 Restart: SOF, then 100 pixels, then a second SOF -> a sof_err pulse and a write at address 0; a full frame after that -> tx_trig after exactly 42240 further writes.
REQ-036 Hold-off: pixels streamed during WAIT_TX -> zero fb_we. frame_tx_done with continuous=0 -> IDLE (busy=0); with continuous=1 -> ARMED, and the next SOF is captured.
REQ-037 Reset mid-capture: reset at pixel 5000 -> outputs return to their reset values the next cycle, with no tx_trig. Pixels streamed afterwards without a capture_req -> no writes.
REQ-038 Ignored events: capture_req during CAPTURE, and frame_tx_done during ARMED -> no change in state or in the counter.
